// File: rtl/key_entry_pkg.sv
// rtl/key_entry_pkg.sv - shared constants and entry type for key entry capture
package key_entry_pkg;

   localparam int KEY_N        = 4;
   localparam int KEY_IDX_W    = 2;
   localparam int SW_W_DEFAULT = 18;

   typedef struct packed {
      logic [KEY_IDX_W-1:0]    key;
      logic [SW_W_DEFAULT-1:0] sw;
   } entry_t;

endpackage

// File: rtl/key_entry_capture_debounce.sv
// rtl/key_entry_capture_debounce.sv - synchroniser, debouncer and press pulse for one key
module key_debounce
   import key_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchroniser, then accept a new level only after it has been
   // seen continuously; press pulses in the cycle after stable drops to 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         stable <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync2;
            cnt    <= '0;
            press  <= stable;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/key_entry_capture.sv
// rtl/key_entry_capture.sv - debounced key press capture into a FWFT FIFO
module key_entry_capture
   import key_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DEPTH           = 4,
   parameter int SW_W            = SW_W_DEFAULT
) (
   input  logic                   ref_clk_clk,
   input  logic                   ref_reset_reset,
   input  logic [KEY_N-1:0]       key_n,
   input  logic [SW_W-1:0]        switches,
   input  logic                   rd_en,
   output logic                   rd_valid,
   output logic [SW_W-1:0]        rd_sw,
   output logic [KEY_IDX_W-1:0]   rd_key,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   input  logic                   clear_ovf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = KEY_IDX_W + SW_W;

   logic [KEY_N-1:0]     press;
   logic [SW_W-1:0]      sw_s1;
   logic [SW_W-1:0]      sw_s2;
   logic [ENT_W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [KEY_IDX_W-1:0] sel_key;
   logic                 any_press;
   logic                 multi_press;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 drop;

   for (genvar g = 0; g < KEY_N; g++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (ref_clk_clk),
         .reset (ref_reset_reset),
         .key_n (key_n[g]),
         .press (press[g])
      );
   end

   // Switch synchroniser; same two-stage delay as the keys so the snapshot
   // lines up with the press pulse.
   always_ff @(posedge ref_clk_clk) begin
      if (ref_reset_reset) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= switches;
         sw_s2 <= sw_s1;
      end
   end

   // Lowest key index wins; any extra press, or a push into a full FIFO
   // with no pop to make room, counts as a drop.
   always_comb begin
      sel_key = '0;
      for (int i = KEY_N - 1; i >= 0; i--) begin
         if (press[i]) sel_key = KEY_IDX_W'(i);
      end
      any_press   = |press;
      multi_press = $countones(press) > 1;
      full        = (count == CNT_W'(DEPTH));
      pop         = rd_en && (count != '0);
      push        = any_press && (!full || pop);
      drop        = multi_press || (any_press && !push);
   end

   // Circular buffer storage, pointers, occupancy and sticky overflow.
   always_ff @(posedge ref_clk_clk) begin
      if (ref_reset_reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {sel_key, sw_s2};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (drop) overflow <= 1'b1;
         else if (clear_ovf) overflow <= 1'b0;
      end
   end

   assign rd_valid        = (count != '0);
   assign {rd_key, rd_sw} = mem[rd_ptr];

endmodule
